// File: rtl/mem_access_stage_pkg.sv
// Shared widths, load-op encodings and the EX->MEM bus layout for the MEM stage.
package mem_access_stage_pkg;

    localparam int SIDE_WD   = 62;
    localparam int ES_BUS_WD = SIDE_WD + 110;
    localparam int MS_BUS_WD = SIDE_WD + 74;

    localparam logic [2:0] LD_OP_LW   = 3'd0;
    localparam logic [2:0] LD_OP_LB   = 3'd1;
    localparam logic [2:0] LD_OP_LBU  = 3'd2;
    localparam logic [2:0] LD_OP_LH   = 3'd3;
    localparam logic [2:0] LD_OP_LHU  = 3'd4;
    localparam logic [2:0] LD_OP_LWL  = 3'd5;
    localparam logic [2:0] LD_OP_LWR  = 3'd6;
    localparam logic [2:0] LD_OP_NONE = 3'd7;

    typedef struct packed {
        logic [SIDE_WD-1:0] side;
        logic               ex;
        logic               ld_req;
        logic [2:0]         ld_op;
        logic [3:0]         gr_strb;
        logic [4:0]         dest;
        logic [31:0]        rt;
        logic [31:0]        alu_res;
        logic [31:0]        pc;
    } es_bus_t;

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Combinational load data alignment: byte/half select with sign/zero extend, lwl/lwr merge into rt.
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] rt,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
        endcase
    end

    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    // lwl fills rt from the top down, lwr from the bottom up (little-endian)
    always_comb begin
        result = rdata;
        case (ld_op)
            LD_OP_LW:   result = rdata;
            LD_OP_NONE: result = rdata;
            LD_OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LD_OP_LBU:  result = {24'd0, byte_sel};
            LD_OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            LD_OP_LHU:  result = {16'd0, half_sel};
            LD_OP_LWL: begin
                case (offset)
                    2'd0: result = {rdata[7:0],  rt[23:0]};
                    2'd1: result = {rdata[15:0], rt[15:0]};
                    2'd2: result = {rdata[23:0], rt[7:0]};
                    2'd3: result = rdata;
                endcase
            end
            LD_OP_LWR: begin
                case (offset)
                    2'd0: result = rdata;
                    2'd1: result = {rt[31:24], rdata[31:8]};
                    2'd2: result = {rt[31:16], rdata[31:16]};
                    2'd3: result = {rt[31:8],  rdata[31:24]};
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: holds one instruction, waits for load data, buffers it under WB backpressure,
// and drops the late data_ok of a load that was flushed while waiting.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    output logic                 ms_allowin,
    input  logic                 es_to_ms_valid,
    input  logic [ES_BUS_WD-1:0] es_to_ms_bus,
    input  logic                 ws_allowin,
    output logic                 ms_to_ws_valid,
    output logic [MS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 ws_do_flush,
    output logic                 ms_ex,
    output logic [4:0]           ms_fwd_dest,
    output logic [31:0]          ms_fwd_data,
    output logic                 ms_fwd_busy
);

    // Held-instruction view: IDLE = !ms_valid, WAIT = load without data, READY = buf_valid or data_ok.
    logic        ms_valid_q, ms_valid_d;
    logic        buf_valid_q, buf_valid_d;
    logic        drop_q, drop_d;
    logic [31:0] buf_rdata_q, buf_rdata_d;
    es_bus_t     bus_q, bus_d;
    es_bus_t     es_bus;

    logic        data_ok_live;
    logic        load_wait;
    logic        ready_go;
    logic        accept;
    logic [31:0] rdata_sel;
    logic [31:0] load_result;
    logic [31:0] final_result;

    assign es_bus       = es_to_ms_bus;
    assign data_ok_live = data_sram_data_ok & ~drop_q;
    assign load_wait    = bus_q.ld_req & ~bus_q.ex & ~buf_valid_q;
    assign ready_go     = bus_q.ex | ~bus_q.ld_req | buf_valid_q | data_ok_live;
    assign ms_allowin   = ~ms_valid_q | (ready_go & ws_allowin);
    assign accept       = ms_allowin & es_to_ms_valid;

    assign rdata_sel = buf_valid_q ? buf_rdata_q : data_sram_rdata;

    mem_access_stage_load_align u_load_align (
        .ld_op  (bus_q.ld_op),
        .offset (bus_q.alu_res[1:0]),
        .rdata  (rdata_sel),
        .rt     (bus_q.rt),
        .result (load_result)
    );

    assign final_result = (bus_q.ld_req & ~bus_q.ex) ? load_result : bus_q.alu_res;

    always_comb begin
        ms_valid_d  = ms_valid_q;
        buf_valid_d = buf_valid_q;
        buf_rdata_d = buf_rdata_q;
        drop_d      = drop_q;
        bus_d       = bus_q;

        if (accept) begin
            bus_d = es_bus;
        end

        if (ms_allowin) begin
            ms_valid_d  = es_to_ms_valid;
            buf_valid_d = 1'b0;
        end else if (ms_valid_q && load_wait && data_ok_live) begin
            buf_valid_d = 1'b1;
            buf_rdata_d = data_sram_rdata;
        end

        if (ws_do_flush) begin
            ms_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
        end

        // A stale data_ok clears drop; a flush of a still-waiting load arms it (even on that same edge).
        if (drop_q && data_sram_data_ok) begin
            drop_d = 1'b0;
        end
        if (ws_do_flush && ms_valid_q && load_wait && !data_ok_live) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            buf_valid_q <= buf_valid_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        bus_q       <= bus_d;
        buf_rdata_q <= buf_rdata_d;
    end

    assign ms_to_ws_valid = ms_valid_q & ready_go;
    assign ms_to_ws_bus   = {bus_q.side, bus_q.ex, bus_q.gr_strb, bus_q.dest, final_result, bus_q.pc};
    assign ms_ex          = ms_valid_q & bus_q.ex;
    assign ms_fwd_dest    = (ms_valid_q && (bus_q.gr_strb != 4'd0)) ? bus_q.dest : 5'd0;
    assign ms_fwd_data    = final_result;
    assign ms_fwd_busy    = ms_valid_q & load_wait & ~data_ok_live;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; a scoreboard queue holds the bus each instruction must deliver to WB.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 ms_allowin;
    logic                 es_to_ms_valid;
    logic [ES_BUS_WD-1:0] es_to_ms_bus;
    logic                 ws_allowin;
    logic                 ms_to_ws_valid;
    logic [MS_BUS_WD-1:0] ms_to_ws_bus;
    logic                 data_sram_data_ok;
    logic [31:0]          data_sram_rdata;
    logic                 ws_do_flush;
    logic                 ms_ex;
    logic [4:0]           ms_fwd_dest;
    logic [31:0]          ms_fwd_data;
    logic                 ms_fwd_busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [MS_BUS_WD-1:0] sb_q[$];
    logic [MS_BUS_WD-1:0] mon_exp;

    mem_access_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_do_flush       (ws_do_flush),
        .ms_ex             (ms_ex),
        .ms_fwd_dest       (ms_fwd_dest),
        .ms_fwd_data       (ms_fwd_data),
        .ms_fwd_busy       (ms_fwd_busy)
    );

    always #5 clk = ~clk;

    // WB side: every handshake must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (resetn && ms_to_ws_valid && ws_allowin && !ws_do_flush) begin
            total_cnt++;
            if (sb_q.size() == 0) begin
                $error("FAIL sb_unexpected observed=%h expected=none", ms_to_ws_bus);
            end else begin
                mon_exp = sb_q.pop_front();
                assert (ms_to_ws_bus === mon_exp) pass_cnt++;
                else $error("FAIL sb_bus observed=%h expected=%h", ms_to_ws_bus, mon_exp);
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [ES_BUS_WD-1:0] mk_es(input logic ex, input logic ld_req,
                                                   input logic [2:0] op, input logic [3:0] strb,
                                                   input logic [4:0] dest, input logic [31:0] rt,
                                                   input logic [31:0] alu, input logic [31:0] pc,
                                                   input logic [SIDE_WD-1:0] side);
        es_bus_t b;
        b.side    = side;
        b.ex      = ex;
        b.ld_req  = ld_req;
        b.ld_op   = op;
        b.gr_strb = strb;
        b.dest    = dest;
        b.rt      = rt;
        b.alu_res = alu;
        b.pc      = pc;
        return b;
    endfunction

    function automatic logic [MS_BUS_WD-1:0] mk_ms(input logic [SIDE_WD-1:0] side, input logic ex,
                                                   input logic [3:0] strb, input logic [4:0] dest,
                                                   input logic [31:0] res, input logic [31:0] pc);
        return {side, ex, strb, dest, res, pc};
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the instruction was accepted.
    task automatic send(input logic [ES_BUS_WD-1:0] bus, input bit push,
                        input logic [MS_BUS_WD-1:0] exp);
        int n;
        n = 0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        @(negedge clk);
        while (!ms_allowin && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total_cnt++;
            $error("FAIL send_timeout observed=allowin_low expected=allowin_high");
        end
        if (push) sb_q.push_back(exp);
        step();
        es_to_ms_valid = 1'b0;
    endtask

    function automatic logic [SIDE_WD-1:0] rnd_side();
        return SIDE_WD'({$urandom(), $urandom()});
    endfunction

    logic [2:0]  t_op   [6] = '{LD_OP_LWL, LD_OP_LWR, LD_OP_LH, LD_OP_LHU, LD_OP_LBU, LD_OP_LW};
    logic [1:0]  t_off  [6] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
    logic [3:0]  t_strb [6] = '{4'b1100, 4'b0111, 4'hF, 4'hF, 4'hF, 4'hF};
    logic [31:0] t_rt   [6] = '{32'hAABBCCDD, 32'hAABBCCDD, 32'h0, 32'h0, 32'h0, 32'h5555AAAA};
    logic [31:0] t_rd   [6] = '{32'h11223344, 32'h11223344, 32'h80011234, 32'h80011234,
                                32'h80011234, 32'hCAFEF00D};
    logic [31:0] t_exp  [6] = '{32'h3344CCDD, 32'hAA112233, 32'hFFFF8001, 32'h00001234,
                                32'h00000012, 32'hCAFEF00D};

    initial begin
        logic [SIDE_WD-1:0] side;
        logic [31:0]        alu;
        logic [31:0]        pc;
        logic [4:0]         prev_dest;

        resetn = 1'b0;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        ws_allowin = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        ws_do_flush = 1'b0;
        prev_dest = 5'd0;

        repeat (3) step();
        settle();
        chk1("rst_valid", ms_to_ws_valid, 1'b0);
        chk1("rst_allowin", ms_allowin, 1'b1);
        chk1("rst_ex", ms_ex, 1'b0);
        chk32("rst_fwd_dest", 32'(ms_fwd_dest), 32'd0);
        chk1("rst_busy", ms_fwd_busy, 1'b0);
        step();
        resetn = 1'b1;
        ws_allowin = 1'b1;
        step();

        // Back-to-back ALU ops: one per cycle
        for (int i = 0; i < 4; i++) begin
            side = rnd_side();
            alu  = 32'h1000_0000 + 32'(i * 17);
            pc   = 32'hBFC0_0000 + 32'(i * 4);
            es_to_ms_valid = 1'b1;
            es_to_ms_bus = mk_es(1'b0, 1'b0, LD_OP_NONE, 4'hF, 5'(i + 4), 32'h0, alu, pc, side);
            sb_q.push_back(mk_ms(side, 1'b0, 4'hF, 5'(i + 4), alu, pc));
            settle();
            chk1("alu_allowin", ms_allowin, 1'b1);
            if (i > 0) begin
                chk1("alu_thru_valid", ms_to_ws_valid, 1'b1);
                chk32("alu_fwd_dest", 32'(ms_fwd_dest), 32'(prev_dest));
            end
            prev_dest = 5'(i + 4);
            step();
        end
        es_to_ms_valid = 1'b0;
        settle();
        chk1("alu_last_valid", ms_to_ws_valid, 1'b1);
        chk32("alu_last_fwd", ms_fwd_data, 32'h1000_0033);
        step();

        // lb with data_ok two cycles late
        side = rnd_side();
        send(mk_es(1'b0, 1'b1, LD_OP_LB, 4'hF, 5'd3, 32'h0, 32'h0000_1003, 32'hBFC0_0100, side),
             1'b1, mk_ms(side, 1'b0, 4'hF, 5'd3, 32'hFFFF_FF80, 32'hBFC0_0100));
        settle();
        chk1("lb_busy1", ms_fwd_busy, 1'b1);
        chk1("lb_allowin_wait", ms_allowin, 1'b0);
        step();
        settle();
        chk1("lb_busy2", ms_fwd_busy, 1'b1);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h8011_2233;
        settle();
        chk1("lb_busy_done", ms_fwd_busy, 1'b0);
        chk1("lb_valid", ms_to_ws_valid, 1'b1);
        chk32("lb_fwd_data", ms_fwd_data, 32'hFFFF_FF80);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        settle();
        chk1("lb_gone", ms_to_ws_valid, 1'b0);
        step();

        // Alignment table, data_ok the cycle after accept
        for (int i = 0; i < 6; i++) begin
            side = rnd_side();
            alu  = 32'h0000_2000 | 32'(t_off[i]);
            pc   = 32'hBFC0_0200 + 32'(i * 4);
            send(mk_es(1'b0, 1'b1, t_op[i], t_strb[i], 5'(i + 10), t_rt[i], alu, pc, side),
                 1'b1, mk_ms(side, 1'b0, t_strb[i], 5'(i + 10), t_exp[i], pc));
            data_sram_data_ok = 1'b1;
            data_sram_rdata = t_rd[i];
            settle();
            chk32("align_fwd_data", ms_fwd_data, t_exp[i]);
            step();
            data_sram_data_ok = 1'b0;
        end

        // data_ok while WB stalls: buffered, emitted once
        ws_allowin = 1'b0;
        side = rnd_side();
        send(mk_es(1'b0, 1'b1, LD_OP_LW, 4'hF, 5'd7, 32'h0, 32'h0000_3000, 32'hBFC0_0300, side),
             1'b1, mk_ms(side, 1'b0, 4'hF, 5'd7, 32'h1357_9BDF, 32'hBFC0_0300));
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h1357_9BDF;
        settle();
        chk1("buf_valid_now", ms_to_ws_valid, 1'b1);
        chk1("buf_allowin_now", ms_allowin, 1'b0);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk1("buf_allowin_hold", ms_allowin, 1'b0);
            chk1("buf_valid_hold", ms_to_ws_valid, 1'b1);
            chk32("buf_data_hold", ms_fwd_data, 32'h1357_9BDF);
            step();
        end
        ws_allowin = 1'b1;
        settle();
        chk1("buf_release_allowin", ms_allowin, 1'b1);
        step();
        settle();
        chk1("buf_emitted_once", ms_to_ws_valid, 1'b0);
        step();

        // Flush while waiting; stale data_ok arrives while the next load waits
        side = rnd_side();
        send(mk_es(1'b0, 1'b1, LD_OP_LW, 4'hF, 5'd8, 32'h0, 32'h0000_4000, 32'hBFC0_0400, side),
             1'b0, '0);
        ws_do_flush = 1'b1;
        settle();
        chk1("flush_busy", ms_fwd_busy, 1'b1);
        step();
        ws_do_flush = 1'b0;
        settle();
        chk1("flush_cleared", ms_to_ws_valid, 1'b0);
        step();
        side = rnd_side();
        send(mk_es(1'b0, 1'b1, LD_OP_LW, 4'hF, 5'd9, 32'h0, 32'h0000_4004, 32'hBFC0_0404, side),
             1'b1, mk_ms(side, 1'b0, 4'hF, 5'd9, 32'h1234_5678, 32'hBFC0_0404));
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hDEAD_BEEF;
        settle();
        chk1("drop_no_valid", ms_to_ws_valid, 1'b0);
        chk1("drop_still_busy", ms_fwd_busy, 1'b1);
        step();
        data_sram_data_ok = 1'b0;
        settle();
        chk1("drop_cleared_busy", ms_fwd_busy, 1'b1);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h1234_5678;
        settle();
        chk1("drop_next_valid", ms_to_ws_valid, 1'b1);
        step();
        data_sram_data_ok = 1'b0;

        // Flush in the same cycle as data_ok: nothing to drop
        side = rnd_side();
        send(mk_es(1'b0, 1'b1, LD_OP_LW, 4'hF, 5'd11, 32'h0, 32'h0000_5000, 32'hBFC0_0500, side),
             1'b0, '0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h0BAD_F00D;
        ws_do_flush = 1'b1;
        settle();
        step();
        data_sram_data_ok = 1'b0;
        ws_do_flush = 1'b0;
        side = rnd_side();
        send(mk_es(1'b0, 1'b1, LD_OP_LW, 4'hF, 5'd12, 32'h0, 32'h0000_5004, 32'hBFC0_0504, side),
             1'b1, mk_ms(side, 1'b0, 4'hF, 5'd12, 32'h2468_1357, 32'hBFC0_0504));
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h2468_1357;
        settle();
        chk1("noflushdrop_busy", ms_fwd_busy, 1'b0);
        chk1("noflushdrop_valid", ms_to_ws_valid, 1'b1);
        step();
        data_sram_data_ok = 1'b0;

        // Excepting instruction with no register write
        ws_allowin = 1'b0;
        side = rnd_side();
        send(mk_es(1'b1, 1'b0, LD_OP_NONE, 4'h0, 5'd9, 32'h0, 32'hBADA_DD01, 32'hBFC0_0600, side),
             1'b1, mk_ms(side, 1'b1, 4'h0, 5'd9, 32'hBADA_DD01, 32'hBFC0_0600));
        settle();
        chk1("ex_flag", ms_ex, 1'b1);
        chk1("ex_ready", ms_to_ws_valid, 1'b1);
        chk32("ex_fwd_dest_zero", 32'(ms_fwd_dest), 32'd0);
        step();
        ws_allowin = 1'b1;
        settle();
        step();
        settle();
        chk1("ex_gone", ms_ex, 1'b0);

        repeat (3) step();
        chk32("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
